// File: rtl/seq_split_multiplier.sv
// Sequential split multiplier: forms the four partial products of the high/low
// operand halves one per cycle on a single shared multiplier and accumulates them.
module seq_split_multiplier #(
    parameter int WIDTH = 16,
    parameter int SPLIT = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 approx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    localparam int HW = WIDTH - SPLIT;
    localparam int MW = (HW > SPLIT) ? HW : SPLIT;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HH   = 3'd1,
        HL   = 3'd2,
        LH   = 3'd3,
        LL   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              approx_r;
    logic [PW-1:0]     acc_r;
    logic [PW-1:0]     p_r;
    logic [MW-1:0]     mul_a_s;
    logic [MW-1:0]     mul_b_s;
    logic [2*MW-1:0]   prod_s;
    logic [PW-1:0]     prod_ext_s;
    logic [PW-1:0]     term_s;
    logic [PW-1:0]     acc_next_s;
    logic              accept_s;

    // Status outputs decoded from state; in_ready stays low while reset is held.
    always_comb begin
        in_ready  = (state_r == IDLE) && !rst;
        busy      = (state_r != IDLE);
        out_valid = (state_r == DONE);
        P         = p_r;
        accept_s  = in_valid && in_ready;
    end

    // Route the operand halves of the current phase into the shared multiplier.
    always_comb begin
        mul_a_s = {MW{1'b0}};
        mul_b_s = {MW{1'b0}};
        case (state_r)
            HH: begin
                mul_a_s[HW-1:0] = a_r[WIDTH-1:SPLIT];
                mul_b_s[HW-1:0] = b_r[WIDTH-1:SPLIT];
            end
            HL: begin
                mul_a_s[HW-1:0]    = a_r[WIDTH-1:SPLIT];
                mul_b_s[SPLIT-1:0] = b_r[SPLIT-1:0];
            end
            LH: begin
                mul_a_s[SPLIT-1:0] = a_r[SPLIT-1:0];
                mul_b_s[HW-1:0]    = b_r[WIDTH-1:SPLIT];
            end
            LL: begin
                mul_a_s[SPLIT-1:0] = a_r[SPLIT-1:0];
                mul_b_s[SPLIT-1:0] = b_r[SPLIT-1:0];
            end
            default: begin
                mul_a_s = {MW{1'b0}};
                mul_b_s = {MW{1'b0}};
            end
        endcase
    end

    assign prod_s = {{MW{1'b0}}, mul_a_s} * {{MW{1'b0}}, mul_b_s};

    // Align the partial product to its weight and add it to the running sum.
    always_comb begin
        prod_ext_s             = {PW{1'b0}};
        prod_ext_s[2*MW-1:0]   = prod_s;
        case (state_r)
            HH:      term_s = prod_ext_s << (2 * SPLIT);
            HL:      term_s = prod_ext_s << SPLIT;
            LH:      term_s = prod_ext_s << SPLIT;
            LL:      term_s = prod_ext_s;
            default: term_s = {PW{1'b0}};
        endcase
        acc_next_s = acc_r + term_s;
    end

    // Next-state logic; approximate mode skips the low x low phase.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = HH;
                else          state_next_s = IDLE;
            end
            HH: state_next_s = HL;
            HL: state_next_s = LH;
            LH: begin
                if (approx_r) state_next_s = DONE;
                else          state_next_s = LL;
            end
            LL: state_next_s = DONE;
            DONE: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, accumulation, and result latch on the way into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            approx_r <= 1'b0;
            acc_r    <= {PW{1'b0}};
            p_r      <= {PW{1'b0}};
        end else begin
            if (accept_s) begin
                a_r      <= A;
                b_r      <= B;
                approx_r <= approx;
                acc_r    <= {PW{1'b0}};
            end else begin
                case (state_r)
                    HH, HL, LH, LL: acc_r <= acc_next_s;
                    default:        acc_r <= acc_r;
                endcase
            end
            if ((state_next_s == DONE) && (state_r != DONE)) begin
                p_r <= acc_next_s;
            end else begin
                p_r <= p_r;
            end
        end
    end

endmodule

// File: tb/tb_seq_split_multiplier.sv
// Directed and randomised bench for seq_split_multiplier with a result scoreboard.
module tb_seq_split_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, approx, out_valid, out_ready, busy;
    logic [15:0] A, B;
    logic [31:0] P;

    logic        in_valid8, approx8, out_ready8;
    logic [7:0]  a8, b8;
    logic        rdy1, ov1, busy1, rdy7, ov7, busy7;
    logic [15:0] p1, p7;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [15:0] q1[$];
    logic [15:0] q7[$];
    logic [31:0] last_exp;

    always #5 clk = ~clk;

    seq_split_multiplier #(.WIDTH(16), .SPLIT(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .approx(approx), .out_valid(out_valid),
        .out_ready(out_ready), .P(P), .busy(busy)
    );

    seq_split_multiplier #(.WIDTH(8), .SPLIT(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(rdy1),
        .A(a8), .B(b8), .approx(approx8), .out_valid(ov1),
        .out_ready(out_ready8), .P(p1), .busy(busy1)
    );

    seq_split_multiplier #(.WIDTH(8), .SPLIT(7)) dut_s7 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(rdy7),
        .A(a8), .B(b8), .approx(approx8), .out_valid(ov7),
        .out_ready(out_ready8), .P(p7), .busy(busy7)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic ap);
        logic [31:0] full;
        logic [31:0] ll;
        full = {16'd0, a} * {16'd0, b};
        ll   = {26'd0, a[5:0]} * {26'd0, b[5:0]};
        return ap ? (full - ll) : full;
    endfunction

    // Called #1 after an edge; drives one transfer and pushes its expected result.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ap,
                         input logic [31:0] expv);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("issue_ready", {63'd0, in_ready}, 64'd1);
        A = a; B = b; approx = ap; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(expv);
        check("ready_drop", {63'd0, in_ready}, 64'd0);
        check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic collect(input string tag, input int lat);
        int e;
        logic [31:0] expv;
        e = 0;
        while (out_valid !== 1'b1 && e < 20) begin
            @(posedge clk); #1; e++;
        end
        check({tag, "_latency"}, 64'(e), 64'(lat));
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        else                  expv = 32'hxxxx_xxxx;
        last_exp = expv;
        check({tag, "_P"}, {32'd0, P}, {32'd0, expv});
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_ov_low"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_P_held"}, {32'd0, P}, {32'd0, last_exp});
    endtask

    initial begin
        int e;
        logic accepted;
        logic [15:0] e1, e7;

        rst = 1'b1; in_valid = 1'b0; approx = 1'b0; out_ready = 1'b1;
        A = 16'd0; B = 16'd0;
        in_valid8 = 1'b0; approx8 = 1'b0; out_ready8 = 1'b1; a8 = 8'd0; b8 = 8'd0;
        #23 rst = 1'b0;
        @(posedge clk); #1;

        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_P", {32'd0, P}, 64'd0);

        // Exact and approximate full-scale operands.
        issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        collect("exact_max", 4);
        handshake("exact_max");
        issue(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFDF080);
        collect("approx_max", 3);
        handshake("approx_max");

        // Back-to-back issue with the consumer always ready.
        A = 16'd1234; B = 16'd5678; approx = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(32'h006AE9BC);
        A = 16'd0; B = 16'hABCD;
        e = 0; accepted = 1'b0;
        while (!accepted && e < 20) begin
            if (out_valid === 1'b1) begin
                last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                check("b2b_first_P", {32'd0, P}, {32'd0, last_exp});
            end
            if (in_ready === 1'b1) accepted = 1'b1;
            @(posedge clk); #1; e++;
        end
        in_valid = 1'b0;
        exp_q.push_back(32'd0);
        check("b2b_gap", 64'(e), 64'd6);
        collect("b2b_second", 4);
        handshake("b2b_second");

        // Backpressure: result holds and new requests are ignored.
        out_ready = 1'b0;
        issue(16'h1234, 16'h00FF, 1'b1, model16(16'h1234, 16'h00FF, 1'b1));
        collect("bp", 3);
        for (int i = 0; i < 10; i++) begin
            A = 16'($urandom); B = 16'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_ov_hold", {63'd0, out_valid}, 64'd1);
            check("bp_P_hold", {32'd0, P}, {32'd0, last_exp});
            check("bp_ready_low", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        handshake("bp");
        @(posedge clk); #1;
        check("bp_no_ghost", {63'd0, busy}, 64'd0);

        // Asynchronous reset while in HL.
        issue(16'h4321, 16'h8765, 1'b0, model16(16'h4321, 16'h8765, 1'b0));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid_rst_ov", {63'd0, out_valid}, 64'd0);
        check("mid_rst_P", {32'd0, P}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(16'd3, 16'd5, 1'b0, 32'd15);
        collect("post_rst", 4);
        handshake("post_rst");

        // Random sweep over the two extreme splits of an 8-bit multiplier.
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); approx8 = 1'($urandom_range(0, 1));
            e = 0;
            while (!(rdy1 === 1'b1 && rdy7 === 1'b1) && e < 20) begin
                @(posedge clk); #1; e++;
            end
            in_valid8 = 1'b1;
            @(posedge clk); #1;
            in_valid8 = 1'b0;
            e1 = ({8'd0, a8} * {8'd0, b8}) - (approx8 ? {15'd0, a8[0] & b8[0]} : 16'd0);
            e7 = ({8'd0, a8} * {8'd0, b8})
                 - (approx8 ? ({9'd0, a8[6:0]} * {9'd0, b8[6:0]}) : 16'd0);
            q1.push_back(e1);
            q7.push_back(e7);
            e = 0;
            while (ov1 !== 1'b1 && e < 20) begin
                @(posedge clk); #1; e++;
            end
            check("sweep_ov", {62'd0, ov1, ov7}, 64'd3);
            check("sweep_s1", {48'd0, p1}, {48'd0, (q1.size() > 0) ? q1.pop_front() : 16'hxxxx});
            check("sweep_s7", {48'd0, p7}, {48'd0, (q7.size() > 0) ? q7.pop_front() : 16'hxxxx});
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
